uart_buffered_tx: RTL

Buffered 8-bit UART transmitter. It accepts bytes from a parallel write port into an internal FIFO and serializes them onto `txd_o` as 8N1 frames, one bit per `baud_clk_posedge` tick. It sits beside the UART receiver and shares the same baud-rate generator tick. Producers such as logic-analyzer dump engines can therefore burst several bytes without polling a transmitter-ready flag.

---
 rtl/uart_buffered_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_buffered_tx.sv
// Buffered 8-bit UART transmitter: byte FIFO feeding an 8N1 serializer paced by the baud tick.
// Optional even-parity bit compiled in with `define UART_TX_PARITY_EN.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// WAIT  | byte loaded, waiting for the tick that starts the start bit
// START | start bit on the line
// DATA  | data bit bitcnt_q on the line (LSB first)
// PAR   | parity bit on the line (UART_TX_PARITY_EN only)
// STOP  | stop bit on the line; next tick chains a queued byte or returns to IDLE
module uart_buffered_tx #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_l,
    input  logic          baud_clk_posedge,
    input  logic          wen_i,
    input  logic [7:0]    data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o,
    output logic          txd_o,
    output logic          busy_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PAR
`endif
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          ovf_q;
    logic          wr_acc;
    logic          pop;

    state_t        state_q;
    logic [7:0]    shreg_q;
    logic [2:0]    bitcnt_q;
    logic          txd_q;
    logic          busy_q;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign txd_o   = txd_q;
    assign busy_o  = busy_q;

    // Room is judged on the pre-edge occupancy, so a same-cycle pop never frees a slot.
    assign wr_acc = wen_i && !full_o;
    assign pop    = !empty_o &&
                    ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_clk_posedge));

    always_comb begin
        count_d = count_q;
        if (wr_acc && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_acc && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (wen_i && full_o) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shreg_q <= mem_q[rd_ptr_q];
                        state_q <= S_WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (baud_clk_posedge) begin
                        txd_q   <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_clk_posedge) begin
                        txd_q    <= shreg_q[0];
                        bitcnt_q <= '0;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_clk_posedge) begin
                        if (bitcnt_q != 3'd7) begin
                            txd_q    <= shreg_q[bitcnt_q + 3'd1];
                            bitcnt_q <= bitcnt_q + 3'd1;
                        end else begin
`ifdef UART_TX_PARITY_EN
                            txd_q   <= ^shreg_q;
                            state_q <= S_PAR;
`else
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PAR: begin
                    if (baud_clk_posedge) begin
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_clk_posedge) begin
                        // Chaining here keeps exactly one stop bit between streamed frames.
                        if (pop) begin
                            shreg_q <= mem_q[rd_ptr_q];
                            txd_q   <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
